// File: rtl/obi_delay_responder.sv
// Word-addressed RAM responder for a req/gnt/rvalid port with programmable grant stall,
// fixed response latency and a cap on granted-but-unanswered requests.
module obi_delay_responder #(
    parameter int unsigned Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OW = $clog2(MaxOutstanding + 1);
    localparam logic [3:0]    GNT_DELAY = 4'(GntDelay);
    localparam logic [OW-1:0] MAX_OUT   = OW'(MaxOutstanding);

    if (RespLatency < 1) begin : g_bad_latency
        $error("obi_delay_responder: RespLatency must be at least 1");
    end
    if (MaxOutstanding < 1) begin : g_bad_outstanding
        $error("obi_delay_responder: MaxOutstanding must be at least 1");
    end
    if (GntDelay > 15) begin : g_bad_gnt_delay
        $error("obi_delay_responder: GntDelay must be in 0..15");
    end
    if ((Depth == 0) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $error("obi_delay_responder: Depth must be a power of 2");
    end

    logic [3:0]    stall_cnt;
    logic [OW-1:0] outst_q;
    logic [31:0]   offset;
    logic          in_range;
    logic [IW-1:0] idx;

    logic [31:0] mem [Depth];

    logic        pipe_v [RespLatency];
    logic        pipe_e [RespLatency];
    logic [31:0] pipe_d [RespLatency];

    // Out-of-range accesses never touch memory, so there is no aliasing above Depth.
    assign offset   = addr_i - BaseAddr;
    assign in_range = (addr_i >= BaseAddr) && ((offset >> 2) < 32'(Depth));
    assign idx      = offset[IW+1:2];

    // Registered outstanding count only: a response retiring this cycle frees its slot next cycle.
    assign gnt_o = req_i && !rst_i && (stall_cnt == GNT_DELAY) && (outst_q < MAX_OUT);

    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || gnt_o) begin
            stall_cnt <= 4'd0;
        end else if (stall_cnt != GNT_DELAY) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
        end else if (gnt_o && !rvalid_o) begin
            outst_q <= outst_q + OW'(1);
        end else if (!gnt_o && rvalid_o) begin
            outst_q <= outst_q - OW'(1);
        end
    end

    // Memory is deliberately left out of reset so contents survive a mid-test reset.
    always_ff @(posedge clk_i) begin
        if (gnt_o && in_range && we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_e[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= gnt_o;
            pipe_e[0] <= gnt_o && !in_range;
            pipe_d[0] <= (gnt_o && in_range && !we_i) ? mem[idx] : '0;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rvalid_o = pipe_v[RespLatency-1];
    assign err_o    = pipe_e[RespLatency-1];
    assign rdata_o  = pipe_d[RespLatency-1];

endmodule
